brisc_rob_param: RTL and testbench
==================================

// Module: brisc_rob_param
// PURPOSE
//  Parametrised in-order-commit reorder buffer for the brisc core.
//  - Issue allocates entries in program order.
//  - Execution units complete entries out of order by ticket.
//  - Head entries retire one per cycle to the register file / store buffer.
//  - Adds two register-lookup ports for operand forwarding from uncommitted
//    results, and a precise exception flush at commit.
// PARAMETERS
//  NUM_ENTRIES  16  entry count; power of two, >= 2
//  XLEN         32  result width
//  REG_BITS     5   destination register index width
//  TKT_W        $clog2(NUM_ENTRIES)  ticket width (derived, localparam)
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         async reset, active low
//  alloc_valid    in   1         issue requests an entry
//  alloc_dest     in   REG_BITS  destination register
//  alloc_store    in   1         entry is a store (no register write)
//  alloc_ready    out  1         entry available (not full)
//  alloc_ticket   out  TKT_W     ticket granted (= tail pointer)
//  wb_valid       in   1         execution result valid
//  wb_ticket      in   TKT_W     entry being completed
//  wb_result      in   XLEN      result value
//  wb_xcpt        in   xcpt_e    exception code from execution
//  commit_valid   out  1         head entry complete
//  commit_ready   in   1         consumer accepts head
//  commit_dest    out  REG_BITS  head destination
//  commit_result  out  XLEN      head result
//  commit_store   out  1         head is a store
//  commit_xcpt    out  xcpt_e    head exception code
//  commit_ticket  out  TKT_W     head ticket
//  flush_o        out  1         pulse: exception committed, ROB emptied
//  lkp_reg[2]     in   REG_BITS  lookup register (rs1, rs2)
//  lkp_hit[2]     out  1         younger producer in flight
//  lkp_done[2]    out  1         that producer has completed
//  lkp_data[2]    out  XLEN      that producer's result
// BEHAVIOUR
//  Reset:
//  - head=tail=count=0; all valid/done bits cleared.
//  - All outputs 0; alloc_ready=1.
//  Per-entry state: valid, done, store, dest, result, xcpt.
//  Alloc (alloc_valid & alloc_ready):
//  - Entry[tail] <= valid=1, done=0, xcpt=NO_XCPT.
//  - tail wraps mod NUM_ENTRIES.
//  - alloc_ready = (count != NUM_ENTRIES), from registered count only;
//    no same-cycle commit bypass.
//  Writeback (wb_valid):
//  - If entry[wb_ticket].valid: set done=1, latch result and xcpt.
//  - Else ignored.
//  - Writes are visible to commit/lookup from the next cycle (no comb bypass).
//  Commit:
//  - commit_valid = valid[head] & done[head]; commit_* driven comb from head.
//  - Handshake commit_valid & commit_ready: clear entry, head++ (wrap), count--.
//  - Alloc and commit in the same cycle: count unchanged.
//  Exception (handshake with commit_xcpt != NO_XCPT):
//  - Entry is still presented/retired.
//  - Next cycle: all entries invalid, head=tail=count=0, flush_o=1
//    for exactly one cycle.
//  - An alloc in the same cycle as the exception commit is discarded.
//  Lookup (comb, registered state only):
//  - Hit if a valid, non-store entry has dest==lkp_reg and lkp_reg!=0.
//  - Youngest match wins: closest to tail-1, searching backwards with wrap.
//  - lkp_done/lkp_data come from that entry.
//  - No hit: lkp_hit=lkp_done=0, lkp_data=0.
//  Boundaries:
//  - Empty: commit_valid=0.
//  - Full: alloc_ready=0; a commit that cycle frees the slot for the next cycle.
//  - wb to head in the same cycle as commit evaluation: commit occurs next cycle.
//  - rst_n low mid-operation: immediate clear, no flush_o pulse.
// TESTING
//  1) Reset, alloc x5,x6,x7 (t0..2); wb t2,t0,t1
//     -> commits in order x5,x6,x7, one per cycle after t1 done.
//  2) Alloc 16 entries without wb -> alloc_ready=0 at count 16.
//     Then wb t0 + commit_ready -> alloc_ready=1 next cycle.
//     Tail wraps to ticket 0.
//  3) Alloc x3 (t0), x3 (t1); wb t0=0xAA
//     -> lkp_reg=3: hit=1, done=0 (t1 youngest).
//     Then wb t1=0xBB -> done=1, data=0xBB.
//     lkp_reg=0 -> hit=0.
//  4) Alloc t0..t3; wb t1 with MEM_UNALIGNED, t0 OK
//     -> t0 commits, t1 commits with xcpt, flush_o=1 one cycle,
//     count=0, alloc_ticket=0.
//  5) commit_ready=0 with head done -> commit_valid held, stable outputs;
//     wb to an unallocated ticket -> no state change.
//  6) Assert rst_n low with 5 entries in flight
//     -> all outputs 0 asynchronously, alloc_ready=1 after release.

Source files
------------

// File: rtl/brisc_rob_param.sv
// brisc reorder buffer: in-order commit, out-of-order writeback by ticket,
// two forwarding lookup ports and a precise exception flush at commit.
package brisc_rob_pkg;
    typedef enum logic [2:0] {
        NO_XCPT       = 3'd0,
        ILLEGAL_INSN  = 3'd1,
        MEM_UNALIGNED = 3'd2,
        MEM_FAULT     = 3'd3,
        ECALL         = 3'd4
    } xcpt_e;
endpackage

module brisc_rob_param
    import brisc_rob_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int XLEN        = 32,
    parameter int REG_BITS    = 5,
    localparam int TKT_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_valid,
    input  logic [REG_BITS-1:0] alloc_dest,
    input  logic                alloc_store,
    output logic                alloc_ready,
    output logic [TKT_W-1:0]    alloc_ticket,
    input  logic                wb_valid,
    input  logic [TKT_W-1:0]    wb_ticket,
    input  logic [XLEN-1:0]     wb_result,
    input  xcpt_e               wb_xcpt,
    output logic                commit_valid,
    input  logic                commit_ready,
    output logic [REG_BITS-1:0] commit_dest,
    output logic [XLEN-1:0]     commit_result,
    output logic                commit_store,
    output xcpt_e               commit_xcpt,
    output logic [TKT_W-1:0]    commit_ticket,
    output logic                flush_o,
    input  logic [REG_BITS-1:0] lkp_reg  [2],
    output logic                lkp_hit  [2],
    output logic                lkp_done [2],
    output logic [XLEN-1:0]     lkp_data [2]
);

    localparam int CNT_W = TKT_W + 1;

    logic [NUM_ENTRIES-1:0] vld_q;
    logic [NUM_ENTRIES-1:0] done_q;
    logic [NUM_ENTRIES-1:0] store_q;
    logic [REG_BITS-1:0]    dest_q [NUM_ENTRIES];
    logic [XLEN-1:0]        res_q  [NUM_ENTRIES];
    xcpt_e                  xcpt_q [NUM_ENTRIES];

    logic [TKT_W-1:0] head_q;
    logic [TKT_W-1:0] tail_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flush_q;

    logic do_alloc;
    logic do_commit;
    logic do_flush;

    assign alloc_ready  = (cnt_q != CNT_W'(NUM_ENTRIES));
    assign alloc_ticket = tail_q;
    assign flush_o      = flush_q;

    // Head fields are gated so an idle head never exposes stale data.
    assign commit_valid  = vld_q[head_q] & done_q[head_q];
    assign commit_dest   = commit_valid ? dest_q[head_q] : '0;
    assign commit_result = commit_valid ? res_q[head_q] : '0;
    assign commit_store  = commit_valid & store_q[head_q];
    assign commit_xcpt   = commit_valid ? xcpt_q[head_q] : NO_XCPT;
    assign commit_ticket = head_q;

    assign do_alloc  = alloc_valid & alloc_ready;
    assign do_commit = commit_valid & commit_ready;
    assign do_flush  = do_commit & (commit_xcpt != NO_XCPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            done_q  <= '0;
            store_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                dest_q[i] <= '0;
                res_q[i]  <= '0;
                xcpt_q[i] <= NO_XCPT;
            end
        end else begin
            flush_q <= do_flush;
            if (do_flush) begin
                vld_q  <= '0;
                done_q <= '0;
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (wb_valid && vld_q[wb_ticket]) begin
                    done_q[wb_ticket] <= 1'b1;
                    res_q[wb_ticket]  <= wb_result;
                    xcpt_q[wb_ticket] <= wb_xcpt;
                end
                if (do_commit) begin
                    vld_q[head_q]  <= 1'b0;
                    done_q[head_q] <= 1'b0;
                    head_q         <= head_q + TKT_W'(1);
                end
                if (do_alloc) begin
                    vld_q[tail_q]   <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                    store_q[tail_q] <= alloc_store;
                    dest_q[tail_q]  <= alloc_dest;
                    res_q[tail_q]   <= '0;
                    xcpt_q[tail_q]  <= NO_XCPT;
                    tail_q          <= tail_q + TKT_W'(1);
                end
                unique case ({do_alloc, do_commit})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Walk oldest to youngest from head; the last match is the youngest.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            lkp_hit[p]  = 1'b0;
            lkp_done[p] = 1'b0;
            lkp_data[p] = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                logic [TKT_W-1:0] idx;
                idx = head_q + TKT_W'(i);
                if (vld_q[idx] && !store_q[idx] &&
                    dest_q[idx] == lkp_reg[p] && lkp_reg[p] != '0) begin
                    lkp_hit[p]  = 1'b1;
                    lkp_done[p] = done_q[idx];
                    lkp_data[p] = res_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_brisc_rob_param.sv
// Scoreboard bench for brisc_rob_param: reference model at posedge,
// output comparison at negedge, directed checks per scenario.
module tb_brisc_rob_param;
    import brisc_rob_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic        alloc_store;
    logic        alloc_ready;
    logic [3:0]  alloc_ticket;
    logic        wb_valid;
    logic [3:0]  wb_ticket;
    logic [31:0] wb_result;
    xcpt_e       wb_xcpt;
    logic        commit_valid;
    logic        commit_ready;
    logic [4:0]  commit_dest;
    logic [31:0] commit_result;
    logic        commit_store;
    xcpt_e       commit_xcpt;
    logic [3:0]  commit_ticket;
    logic        flush_o;
    logic [4:0]  lkp_reg  [2];
    logic        lkp_hit  [2];
    logic        lkp_done [2];
    logic [31:0] lkp_data [2];

    brisc_rob_param #(.NUM_ENTRIES(16), .XLEN(32), .REG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_store(alloc_store), .alloc_ready(alloc_ready),
        .alloc_ticket(alloc_ticket),
        .wb_valid(wb_valid), .wb_ticket(wb_ticket),
        .wb_result(wb_result), .wb_xcpt(wb_xcpt),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_dest(commit_dest), .commit_result(commit_result),
        .commit_store(commit_store), .commit_xcpt(commit_xcpt),
        .commit_ticket(commit_ticket), .flush_o(flush_o),
        .lkp_reg(lkp_reg), .lkp_hit(lkp_hit),
        .lkp_done(lkp_done), .lkp_data(lkp_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [3:0]  exp_q[$];
    logic [4:0]  m_dest  [16];
    logic [31:0] m_res   [16];
    xcpt_e       m_xcpt  [16];
    bit          m_store [16];
    bit          m_valid [16];
    bit          m_done  [16];
    logic [3:0]  m_head, m_tail;
    bit          m_flush;
    logic [4:0]  log_q[$];

    function automatic bit m_cv();
        return exp_q.size() > 0 && m_done[exp_q[0]];
    endfunction

    task automatic m_lkp(input logic [4:0] r, output bit h, output bit d,
                         output logic [31:0] dat);
        h = 0; d = 0; dat = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (!h && r != 0 && !m_store[exp_q[i]] && m_dest[exp_q[i]] == r) begin
                h = 1; d = m_done[exp_q[i]]; dat = m_res[exp_q[i]];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_head = 0; m_tail = 0; m_flush = 0;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_done[i] = 0; m_store[i] = 0;
                m_dest[i] = 0; m_res[i] = 0; m_xcpt[i] = NO_XCPT;
            end
        end else begin
            bit hs, xc, ar;
            hs = m_cv() && commit_ready;
            xc = hs && m_xcpt[m_head] != NO_XCPT;
            ar = exp_q.size() < 16;
            m_flush = xc;
            if (xc) begin
                exp_q.delete();
                m_head = 0; m_tail = 0;
                for (int i = 0; i < 16; i++) begin
                    m_valid[i] = 0; m_done[i] = 0;
                end
            end else begin
                if (wb_valid && m_valid[wb_ticket]) begin
                    m_done[wb_ticket] = 1;
                    m_res[wb_ticket]  = wb_result;
                    m_xcpt[wb_ticket] = wb_xcpt;
                end
                if (hs) begin
                    void'(exp_q.pop_front());
                    m_valid[m_head] = 0; m_done[m_head] = 0;
                    m_head = m_head + 1;
                end
                if (alloc_valid && ar) begin
                    exp_q.push_back(m_tail);
                    m_valid[m_tail] = 1; m_done[m_tail] = 0;
                    m_store[m_tail] = alloc_store;
                    m_dest[m_tail] = alloc_dest;
                    m_res[m_tail] = 0; m_xcpt[m_tail] = NO_XCPT;
                    m_tail = m_tail + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit h, d;
            logic [31:0] dat;
            chk("alloc_ready", alloc_ready, exp_q.size() < 16);
            chk("alloc_ticket", alloc_ticket, m_tail);
            chk("flush_o", flush_o, m_flush);
            chk("commit_valid", commit_valid, m_cv());
            if (m_cv()) begin
                chk("commit_ticket", commit_ticket, exp_q[0]);
                chk("commit_dest", commit_dest, m_dest[exp_q[0]]);
                chk("commit_result", commit_result, m_res[exp_q[0]]);
                chk("commit_xcpt", commit_xcpt, m_xcpt[exp_q[0]]);
                chk("commit_store", commit_store, m_store[exp_q[0]]);
            end
            for (int p = 0; p < 2; p++) begin
                m_lkp(lkp_reg[p], h, d, dat);
                chk("lkp_hit", lkp_hit[p], h);
                chk("lkp_done", lkp_done[p], d);
                chk("lkp_data", lkp_data[p], dat);
            end
            if (commit_valid && commit_ready) log_q.push_back(commit_dest);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_alloc_ticket", alloc_ticket, 0);
        chk("rst_flush", flush_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic alloc(input logic [4:0] d, input bit st = 0);
        alloc_valid = 1; alloc_dest = d; alloc_store = st;
        step();
        alloc_valid = 0; alloc_store = 0;
    endtask

    task automatic wb(input logic [3:0] t, input logic [31:0] r,
                      input xcpt_e x);
        wb_valid = 1; wb_ticket = t; wb_result = r; wb_xcpt = x;
        step();
        wb_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        alloc_valid = 0; alloc_dest = 0; alloc_store = 0;
        wb_valid = 0; wb_ticket = 0; wb_result = 0; wb_xcpt = NO_XCPT;
        commit_ready = 0; lkp_reg[0] = 0; lkp_reg[1] = 0;
        #1;

        // 1: out-of-order writeback, in-order commit
        do_reset();
        commit_ready = 1;
        alloc(5); alloc(6); alloc(7);
        wb(2, 32'h72, NO_XCPT);
        wb(0, 32'h70, NO_XCPT);
        wb(1, 32'h71, NO_XCPT);
        drain();
        chk("t1_commits", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_c0", log_q[0], 5);
            chk("t1_c1", log_q[1], 6);
            chk("t1_c2", log_q[2], 7);
        end

        // 2: fill, full, free one slot, tail wraps
        do_reset();
        commit_ready = 0;
        for (int i = 0; i < 16; i++) alloc(5'(i + 1));
        chk("t2_full_ready", alloc_ready, 0);
        chk("t2_full_ticket", alloc_ticket, 0);
        alloc(31);
        chk("t2_ovf_ticket", alloc_ticket, 0);
        commit_ready = 1;
        wb(0, 32'h1234, NO_XCPT);
        chk("t2_cv", commit_valid, 1);
        chk("t2_still_full", alloc_ready, 0);
        step();
        commit_ready = 0;
        chk("t2_freed", alloc_ready, 1);
        alloc(20);
        chk("t2_wrap_ticket", alloc_ticket, 1);

        // 3: forwarding lookup, youngest producer wins
        do_reset();
        alloc(3); alloc(3);
        wb(0, 32'hAA, NO_XCPT);
        lkp_reg[0] = 3; lkp_reg[1] = 0;
        #1;
        chk("t3_hit", lkp_hit[0], 1);
        chk("t3_done0", lkp_done[0], 0);
        chk("t3_r0_hit", lkp_hit[1], 0);
        wb(1, 32'hBB, NO_XCPT);
        chk("t3_done1", lkp_done[0], 1);
        chk("t3_data", lkp_data[0], 32'hBB);
        lkp_reg[1] = 9;
        #1;
        chk("t3_miss", lkp_hit[1], 0);
        lkp_reg[0] = 0; lkp_reg[1] = 0;

        // 4: precise exception flush
        do_reset();
        commit_ready = 1;
        alloc(1); alloc(2); alloc(3); alloc(4);
        wb(1, 32'h11, MEM_UNALIGNED);
        wb(0, 32'h10, NO_XCPT);
        for (int i = 0; i < 10; i++) begin
            if (commit_valid && commit_xcpt != NO_XCPT) break;
            step();
        end
        chk("t4_xcpt_ticket", commit_ticket, 1);
        chk("t4_xcpt_code", commit_xcpt, MEM_UNALIGNED);
        lkp_reg[0] = 9;
        alloc(9);
        chk("t4_flush", flush_o, 1);
        chk("t4_ticket0", alloc_ticket, 0);
        chk("t4_empty", commit_valid, 0);
        chk("t4_disc_alloc", lkp_hit[0], 0);
        step();
        chk("t4_flush_1cyc", flush_o, 0);
        chk("t4_commits", log_q.size(), 2);
        lkp_reg[0] = 0;
        commit_ready = 0;

        // 5: back-pressure hold, writeback to unallocated ticket
        do_reset();
        alloc(8);
        wb(0, 32'h55, NO_XCPT);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_cv", commit_valid, 1);
            chk("t5_hold_dest", commit_dest, 8);
            chk("t5_hold_res", commit_result, 32'h55);
            step();
        end
        wb(5, 32'hDEAD, MEM_FAULT);
        chk("t5_stray_ticket", alloc_ticket, 1);
        chk("t5_stray_res", commit_result, 32'h55);
        commit_ready = 1;
        step();
        commit_ready = 0;
        chk("t5_empty", commit_valid, 0);

        // 6: asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(10 + i));
        wb(0, 32'h77, NO_XCPT);
        lkp_reg[0] = 10;
        #1;
        chk("t6_pre_hit", lkp_hit[0], 1);
        chk("t6_pre_ticket", alloc_ticket, 5);
        #2 rst_n = 0;
        #1;
        chk("t6_cv", commit_valid, 0);
        chk("t6_ticket", alloc_ticket, 0);
        chk("t6_ready", alloc_ready, 1);
        chk("t6_hit", lkp_hit[0], 0);
        chk("t6_cdest", commit_dest, 0);
        chk("t6_flush", flush_o, 0);
        step();
        rst_n = 1;
        step();
        chk("t6_post_ready", alloc_ready, 1);
        chk("t6_post_flush", flush_o, 0);
        lkp_reg[0] = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
